// File: rtl/edf_heap_queue.sv
// edf_heap_queue
// Earliest-deadline-first priority queue built as a binary min-heap held in
// a register array. The smallest key is always presented at the pop port.
// Pushes sift up and pops sift down, one heap level per clock. A push and a
// pop accepted in the same cycle replace the top entry and then sift down.
//
// Optional build macro:
//   EDF_HEAP_STATS_EN - adds the max_count output, which holds the high-water
//                       mark of the entry count.
//
// state       | meaning
// ------------+-------------------------------------------------------------
// S_IDLE      | heap is consistent; handshakes are accepted
// S_SIFT_UP   | the entry at r_idx is moving toward the root
// S_SIFT_DOWN | the entry at r_idx is moving toward the leaves

module edf_heap_queue #(
    parameter int ADDR_WIDTH = 4,
    parameter int KEY_WIDTH  = 16,
    parameter int DATA_WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  push_valid,
    output logic                  push_ready,
    input  logic [KEY_WIDTH-1:0]  push_key,
    input  logic [DATA_WIDTH-1:0] push_data,
    output logic                  pop_valid,
    input  logic                  pop_ready,
    output logic [KEY_WIDTH-1:0]  pop_key,
    output logic [DATA_WIDTH-1:0] pop_data,
    output logic [ADDR_WIDTH:0]   count,
    output logic                  full,
    output logic                  empty,
    output logic                  busy
`ifdef EDF_HEAP_STATS_EN
    ,
    output logic [ADDR_WIDTH:0]   max_count
`endif
);

    localparam int DEPTH = 1 << ADDR_WIDTH;
    localparam logic [ADDR_WIDTH:0]   DEPTH_CNT = (ADDR_WIDTH+1)'(DEPTH);
    localparam logic [ADDR_WIDTH:0]   CNT_ONE   = (ADDR_WIDTH+1)'(1);
    localparam logic [ADDR_WIDTH:0]   CNT_TWO   = (ADDR_WIDTH+1)'(2);
    localparam logic [ADDR_WIDTH-1:0] IDX_ONE   = ADDR_WIDTH'(1);
    localparam logic [ADDR_WIDTH+1:0] CHILD_ONE = (ADDR_WIDTH+2)'(1);

    typedef enum logic [1:0] {
        S_IDLE      = 2'd0,
        S_SIFT_UP   = 2'd1,
        S_SIFT_DOWN = 2'd2
    } state_t;

    // Heap storage and control registers
    logic [KEY_WIDTH-1:0]  r_key  [DEPTH];
    logic [DATA_WIDTH-1:0] r_data [DEPTH];
    state_t                r_state;
    logic [ADDR_WIDTH-1:0] r_idx;
    logic [ADDR_WIDTH:0]   r_count;

    // Next-state values
    state_t                w_state_nxt;
    logic [ADDR_WIDTH-1:0] w_idx_nxt;
    logic [ADDR_WIDTH:0]   w_count_nxt;

    // Two array write ports: a swap needs both, every other move needs one
    logic                  w_wa_en;
    logic [ADDR_WIDTH-1:0] w_wa_idx;
    logic [KEY_WIDTH-1:0]  w_wa_key;
    logic [DATA_WIDTH-1:0] w_wa_data;
    logic                  w_wb_en;
    logic [ADDR_WIDTH-1:0] w_wb_idx;
    logic [KEY_WIDTH-1:0]  w_wb_key;
    logic [DATA_WIDTH-1:0] w_wb_data;

    // Handshake and tree-navigation helpers
    logic                  w_idle;
    logic                  w_push_fire;
    logic                  w_pop_fire;
    logic [ADDR_WIDTH-1:0] w_tail_idx;
    logic [ADDR_WIDTH-1:0] w_last_idx;
    logic [ADDR_WIDTH-1:0] w_idx_m1;
    logic [ADDR_WIDTH-1:0] w_parent;
    logic [ADDR_WIDTH+1:0] w_count_ext;
    logic [ADDR_WIDTH+1:0] w_left;
    logic [ADDR_WIDTH+1:0] w_right;
    logic                  w_left_ok;
    logic                  w_right_ok;
    logic [ADDR_WIDTH-1:0] w_left_idx;
    logic [ADDR_WIDTH-1:0] w_right_idx;
    logic [ADDR_WIDTH-1:0] w_sel_idx;
    logic                  w_sel_has_child;

    // Index arithmetic for the node under work; children are 2i+1 and 2i+2
    always_comb begin
        w_tail_idx      = r_count[ADDR_WIDTH-1:0];
        w_last_idx      = ADDR_WIDTH'(r_count - CNT_ONE);
        w_idx_m1        = r_idx - IDX_ONE;
        w_parent        = w_idx_m1 >> 1;
        w_count_ext     = {1'b0, r_count};
        w_left          = {1'b0, r_idx, 1'b1};
        w_right         = w_left + CHILD_ONE;
        w_left_ok       = w_left < w_count_ext;
        w_right_ok      = w_right < w_count_ext;
        w_left_idx      = w_left[ADDR_WIDTH-1:0];
        w_right_idx     = w_right[ADDR_WIDTH-1:0];
        // Ties go to the left child; only a strictly smaller right child wins
        if (w_right_ok && (r_key[w_right_idx] < r_key[w_left_idx])) begin
            w_sel_idx = w_right_idx;
        end else begin
            w_sel_idx = w_left_idx;
        end
        w_sel_has_child = {1'b0, w_sel_idx, 1'b1} < w_count_ext;
    end

    // State, cursor and count registers; reset wins over any handshake
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_idx   <= '0;
            r_count <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_idx   <= w_idx_nxt;
            r_count <= w_count_nxt;
        end
    end

    // Next-state logic: handshakes in IDLE, one heap level per sift cycle
    always_comb begin
        w_state_nxt = r_state;
        w_idx_nxt   = r_idx;
        w_count_nxt = r_count;
        w_wa_en     = 1'b0;
        w_wa_idx    = '0;
        w_wa_key    = '0;
        w_wa_data   = '0;
        w_wb_en     = 1'b0;
        w_wb_idx    = '0;
        w_wb_key    = '0;
        w_wb_data   = '0;
        case (r_state)
            S_IDLE: begin
                if (w_push_fire && w_pop_fire) begin
                    // Replace-top: new entry lands on the root, count is unchanged
                    w_wa_en     = 1'b1;
                    w_wa_idx    = '0;
                    w_wa_key    = push_key;
                    w_wa_data   = push_data;
                    w_idx_nxt   = '0;
                    w_state_nxt = S_SIFT_DOWN;
                end else if (w_push_fire) begin
                    w_wa_en     = 1'b1;
                    w_wa_idx    = w_tail_idx;
                    w_wa_key    = push_key;
                    w_wa_data   = push_data;
                    w_count_nxt = r_count + CNT_ONE;
                    w_idx_nxt   = w_tail_idx;
                    w_state_nxt = S_SIFT_UP;
                end else if (w_pop_fire) begin
                    // Last entry fills the hole at the root
                    w_wa_en     = 1'b1;
                    w_wa_idx    = '0;
                    w_wa_key    = r_key[w_last_idx];
                    w_wa_data   = r_data[w_last_idx];
                    w_count_nxt = r_count - CNT_ONE;
                    w_idx_nxt   = '0;
                    if (r_count > CNT_TWO) begin
                        w_state_nxt = S_SIFT_DOWN;
                    end
                end
            end
            S_SIFT_UP: begin
                if ((r_idx != '0) && (r_key[r_idx] < r_key[w_parent])) begin
                    w_wa_en     = 1'b1;
                    w_wa_idx    = r_idx;
                    w_wa_key    = r_key[w_parent];
                    w_wa_data   = r_data[w_parent];
                    w_wb_en     = 1'b1;
                    w_wb_idx    = w_parent;
                    w_wb_key    = r_key[r_idx];
                    w_wb_data   = r_data[r_idx];
                    w_idx_nxt   = w_parent;
                    // Reaching the root ends the walk without an extra cycle
                    if (w_parent == '0) begin
                        w_state_nxt = S_IDLE;
                    end
                end else begin
                    w_state_nxt = S_IDLE;
                end
            end
            S_SIFT_DOWN: begin
                if (w_left_ok && (r_key[w_sel_idx] < r_key[r_idx])) begin
                    w_wa_en     = 1'b1;
                    w_wa_idx    = r_idx;
                    w_wa_key    = r_key[w_sel_idx];
                    w_wa_data   = r_data[w_sel_idx];
                    w_wb_en     = 1'b1;
                    w_wb_idx    = w_sel_idx;
                    w_wb_key    = r_key[r_idx];
                    w_wb_data   = r_data[r_idx];
                    w_idx_nxt   = w_sel_idx;
                    // Landing on a leaf ends the walk without an extra cycle
                    if (!w_sel_has_child) begin
                        w_state_nxt = S_IDLE;
                    end
                end else begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // Output decode: status flags, handshake readiness and the heap top
    always_comb begin
        w_idle      = (r_state == S_IDLE);
        count       = r_count;
        full        = (r_count == DEPTH_CNT);
        empty       = (r_count == '0);
        busy        = !w_idle;
        pop_valid   = w_idle && !empty;
        push_ready  = w_idle && (!full || (pop_valid && pop_ready));
        w_push_fire = push_valid && push_ready;
        w_pop_fire  = pop_valid && pop_ready;
        pop_key     = pop_valid ? r_key[0]  : '0;
        pop_data    = pop_valid ? r_data[0] : '0;
    end

    // Heap array writes; contents are left as-is on reset since count gates them
    always_ff @(posedge clk) begin
        if (!rst && w_wa_en) begin
            r_key[w_wa_idx]  <= w_wa_key;
            r_data[w_wa_idx] <= w_wa_data;
        end
        if (!rst && w_wb_en) begin
            r_key[w_wb_idx]  <= w_wb_key;
            r_data[w_wb_idx] <= w_wb_data;
        end
    end

`ifdef EDF_HEAP_STATS_EN
    logic [ADDR_WIDTH:0] r_max_count;

    // High-water mark of the entry count, tracked from the next-cycle value
    always_ff @(posedge clk) begin
        if (rst) begin
            r_max_count <= '0;
        end else if (w_count_nxt > r_max_count) begin
            r_max_count <= w_count_nxt;
        end
    end

    assign max_count = r_max_count;
`endif

endmodule

// File: tb/tb_edf_heap_queue.sv
// tb_edf_heap_queue
// Directed scenarios for the EDF heap queue plus a randomized run against a
// simple list model. Build with EDF_HEAP_STATS_EN to also cover max_count.

module tb_edf_heap_queue;

    localparam int AW    = 4;
    localparam int KW    = 16;
    localparam int DW    = 16;
    localparam int DEPTH = 16;

    logic          clk = 1'b0;
    logic          rst;
    logic          push_valid;
    logic          push_ready;
    logic [KW-1:0] push_key;
    logic [DW-1:0] push_data;
    logic          pop_valid;
    logic          pop_ready;
    logic [KW-1:0] pop_key;
    logic [DW-1:0] pop_data;
    logic [AW:0]   count;
    logic          full;
    logic          empty;
    logic          busy;
`ifdef EDF_HEAP_STATS_EN
    logic [AW:0]   max_count;
`endif

    int checks   = 0;
    int failures = 0;

    edf_heap_queue #(
        .ADDR_WIDTH (AW),
        .KEY_WIDTH  (KW),
        .DATA_WIDTH (DW)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .push_valid (push_valid),
        .push_ready (push_ready),
        .push_key   (push_key),
        .push_data  (push_data),
        .pop_valid  (pop_valid),
        .pop_ready  (pop_ready),
        .pop_key    (pop_key),
        .pop_data   (pop_data),
        .count      (count),
        .full       (full),
        .empty      (empty),
        .busy       (busy)
`ifdef EDF_HEAP_STATS_EN
        ,
        .max_count  (max_count)
`endif
    );

    always #5 clk = ~clk;

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        rst = 1'b0;
    endtask

    task automatic wait_idle(input int budget, output int cycles);
        cycles = 0;
        while (busy && cycles < budget) begin
            step();
            cycles++;
        end
        checks++;
        if (busy !== 1'b0) begin
            failures++;
            $display("FAIL wait_idle: busy=%0b after %0d cycles, required 0", busy, cycles);
        end
    endtask

    task automatic do_push(input logic [KW-1:0] k, input logic [DW-1:0] d, output int busy_cyc);
        int n = 0;
        while (!push_ready && n < 50) begin
            step();
            n++;
        end
        checks++;
        if (push_ready !== 1'b1) begin
            failures++;
            $display("FAIL push_wait: push_ready=%0b, required 1", push_ready);
        end
        push_valid = 1'b1;
        push_key   = k;
        push_data  = d;
        step();
        push_valid = 1'b0;
        wait_idle(20, busy_cyc);
    endtask

    task automatic do_pop(output logic [KW-1:0] k, output logic [DW-1:0] d);
        int n = 0;
        int c;
        while (!pop_valid && n < 50) begin
            step();
            n++;
        end
        checks++;
        if (pop_valid !== 1'b1) begin
            failures++;
            $display("FAIL pop_wait: pop_valid=%0b, required 1", pop_valid);
        end
        k = pop_key;
        d = pop_data;
        pop_ready = 1'b1;
        step();
        pop_ready = 1'b0;
        wait_idle(20, c);
    endtask

    task automatic test_reset();
        rst        = 1'b1;
        push_valid = 1'b1;
        push_key   = 16'h0055;
        push_data  = 16'h1234;
        pop_ready  = 1'b0;
        step();
        step();
        checks++;
        if (count !== 5'd0) begin
            failures++;
            $display("FAIL reset_priority_count: got %0d, required 0", count);
        end
        push_valid = 1'b0;
        rst        = 1'b0;
        step();
        checks++;
        if (count !== 5'd0 || empty !== 1'b1 || full !== 1'b0 || busy !== 1'b0 ||
            push_ready !== 1'b1 || pop_valid !== 1'b0) begin
            failures++;
            $display("FAIL reset_state: count=%0d empty=%0b full=%0b busy=%0b push_ready=%0b pop_valid=%0b, required 0 1 0 0 1 0",
                     count, empty, full, busy, push_ready, pop_valid);
        end
    endtask

    task automatic test_push_pop_order();
        logic [KW-1:0] in_k [4] = '{16'd7, 16'd3, 16'd9, 16'd1};
        logic [KW-1:0] ex_k [4] = '{16'd1, 16'd3, 16'd7, 16'd9};
        logic [KW-1:0] k;
        logic [DW-1:0] d;
        int c;
        do_reset();
        for (int i = 0; i < 4; i++) do_push(in_k[i], 16'h0100 | in_k[i], c);
        checks++;
        if (count !== 5'd4) begin
            failures++;
            $display("FAIL order_count: got %0d, required 4", count);
        end
        for (int i = 0; i < 4; i++) begin
            do_pop(k, d);
            checks++;
            if (k !== ex_k[i] || d !== (16'h0100 | ex_k[i])) begin
                failures++;
                $display("FAIL order_pop%0d: got key %0d data %h, required key %0d data %h",
                         i, k, d, ex_k[i], 16'h0100 | ex_k[i]);
            end
        end
        checks++;
        if (empty !== 1'b1) begin
            failures++;
            $display("FAIL order_empty: got %0b, required 1", empty);
        end
    endtask

    task automatic test_full();
        int c = 0;
        do_reset();
        for (int k = 16; k >= 1; k--) do_push(KW'(k), DW'(16'h0200 + k), c);
        // key 1 lands at index 15 and must climb four levels
        checks++;
        if (c > AW) begin
            failures++;
            $display("FAIL sift_up_latency: got %0d busy cycles, required <= %0d", c, AW);
        end
        checks++;
        if (full !== 1'b1 || push_ready !== 1'b0 || count !== 5'd16 || pop_key !== 16'd1) begin
            failures++;
            $display("FAIL full_state: full=%0b push_ready=%0b count=%0d top=%0d, required 1 0 16 1",
                     full, push_ready, count, pop_key);
        end
        push_valid = 1'b1;
        push_key   = 16'd0;
        push_data  = 16'hdead;
        step();
        step();
        step();
        checks++;
        if (count !== 5'd16 || push_ready !== 1'b0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL full_stall: count=%0d push_ready=%0b busy=%0b, required 16 0 0",
                     count, push_ready, busy);
        end
        push_valid = 1'b0;
    endtask

    task automatic test_back_to_back();
        logic [KW-1:0] k;
        logic [DW-1:0] d;
        int c;
        int exp_k;
        push_valid = 1'b1;
        push_key   = 16'd20;
        push_data  = 16'h0214;
        pop_ready  = 1'b1;
        #1;
        checks++;
        if (push_ready !== 1'b1 || pop_key !== 16'd1 || pop_data !== 16'h0201) begin
            failures++;
            $display("FAIL replace_top: push_ready=%0b key=%0d data=%h, required 1 1 0201",
                     push_ready, pop_key, pop_data);
        end
        step();
        push_valid = 1'b0;
        pop_ready  = 1'b0;
        checks++;
        if (count !== 5'd16) begin
            failures++;
            $display("FAIL replace_count: got %0d, required 16", count);
        end
        wait_idle(20, c);
        for (int i = 0; i < 16; i++) begin
            exp_k = (i < 15) ? (i + 2) : 20;
            do_pop(k, d);
            checks++;
            if (k !== KW'(exp_k) || d !== DW'(16'h0200 + exp_k)) begin
                failures++;
                $display("FAIL drain_pop%0d: got key %0d data %h, required key %0d data %h",
                         i, k, d, exp_k, 16'h0200 + exp_k);
            end
        end
        checks++;
        if (empty !== 1'b1 || count !== 5'd0) begin
            failures++;
            $display("FAIL drain_empty: empty=%0b count=%0d, required 1 0", empty, count);
        end
    endtask

    task automatic test_reset_mid_sift();
        logic [KW-1:0] k;
        logic [DW-1:0] d;
        int c;
        do_reset();
        do_push(16'd9, 16'h0009, c);
        push_valid = 1'b1;
        push_key   = 16'd5;
        push_data  = 16'h0005;
        step();
        push_valid = 1'b0;
        checks++;
        if (busy !== 1'b1) begin
            failures++;
            $display("FAIL midsift_busy: got %0b, required 1", busy);
        end
        rst = 1'b1;
        step();
        checks++;
        if (count !== 5'd0 || pop_valid !== 1'b0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL midsift_reset: count=%0d pop_valid=%0b busy=%0b, required 0 0 0",
                     count, pop_valid, busy);
        end
        rst = 1'b0;
        do_push(16'd4, 16'h0044, c);
        do_pop(k, d);
        checks++;
        if (k !== 16'd4 || d !== 16'h0044 || empty !== 1'b1) begin
            failures++;
            $display("FAIL midsift_recover: key=%0d data=%h empty=%0b, required 4 0044 1", k, d, empty);
        end
    endtask

    task automatic test_random();
        int            mk[$];
        int            md[$];
        int            op;
        int            c;
        int            mn;
        int            hit;
        int            uid = 0;
        logic [KW-1:0] k;
        logic [DW-1:0] d;
        logic [KW-1:0] nk;
        do_reset();
        for (int it = 0; it < 1500; it++) begin
            op = $urandom_range(0, 2);
            if (op == 0 && mk.size() < DEPTH) begin
                nk = KW'($urandom_range(0, 31));
                do_push(nk, DW'(uid), c);
                mk.push_back(int'(nk));
                md.push_back(uid);
                uid++;
            end else if (op != 0 && mk.size() > 0) begin
                if (op == 2) begin
                    nk = KW'($urandom_range(0, 31));
                    push_valid = 1'b1;
                    push_key   = nk;
                    push_data  = DW'(uid);
                    pop_ready  = 1'b1;
                    #1;
                    k = pop_key;
                    d = pop_data;
                    step();
                    push_valid = 1'b0;
                    pop_ready  = 1'b0;
                    wait_idle(20, c);
                end else begin
                    do_pop(k, d);
                end
                mn = mk[0];
                foreach (mk[j]) if (mk[j] < mn) mn = mk[j];
                hit = -1;
                foreach (mk[j]) if (mk[j] == int'(k) && md[j] == int'(d)) hit = j;
                checks++;
                if (int'(k) != mn || hit < 0) begin
                    failures++;
                    $display("FAIL rand_pop it=%0d: got key %0d data %0d, required min key %0d of a stored entry",
                             it, k, d, mn);
                end
                if (hit >= 0) begin
                    mk.delete(hit);
                    md.delete(hit);
                end
                if (op == 2) begin
                    mk.push_back(int'(nk));
                    md.push_back(uid);
                    uid++;
                end
            end
            checks++;
            if (int'(count) != mk.size()) begin
                failures++;
                $display("FAIL rand_count it=%0d: got %0d, required %0d", it, count, mk.size());
            end
        end
    endtask

`ifdef EDF_HEAP_STATS_EN
    task automatic test_stats();
        logic [KW-1:0] k;
        logic [DW-1:0] d;
        int c;
        do_reset();
        for (int i = 0; i < 6; i++) do_push(KW'(10 + i), DW'(i), c);
        for (int i = 0; i < 6; i++) do_pop(k, d);
        for (int i = 0; i < 2; i++) do_push(KW'(30 + i), DW'(i), c);
        checks++;
        if (max_count !== 5'd6) begin
            failures++;
            $display("FAIL stats_hwm: got %0d, required 6", max_count);
        end
        do_reset();
        #1;
        checks++;
        if (max_count !== 5'd0) begin
            failures++;
            $display("FAIL stats_reset: got %0d, required 0", max_count);
        end
    endtask
`endif

    initial begin
        rst        = 1'b1;
        push_valid = 1'b0;
        push_key   = '0;
        push_data  = '0;
        pop_ready  = 1'b0;
        step();
        test_reset();
        test_push_pop_order();
        test_full();
        test_back_to_back();
        test_reset_mid_sift();
        test_random();
`ifdef EDF_HEAP_STATS_EN
        test_stats();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
